// File: rtl/ex_mem_stage.sv
// EX stage with the EX/MEM pipeline register. It holds operand forwarding, the ALU, and a
// 32-step shift-add multiplier that stalls the front end until its result is ready.
module ex_mem_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] RS_data_i,
    input  logic [31:0] RT_data_i,
    input  logic [31:0] sign_extend_i,
    input  logic        ALUSrc_i,
    input  logic [1:0]  ALUOp_i,
    input  logic        RegDst_i,
    input  logic [4:0]  instr1115_i,
    input  logic [4:0]  instr1620_i,
    input  logic [1:0]  ctrl_WB_i,
    input  logic [1:0]  ctrl_M_i,
    input  logic [1:0]  ForwardA_i,
    input  logic [1:0]  ForwardB_i,
    input  logic [31:0] EX_MEM_fwd_i,
    input  logic [31:0] MEM_WB_fwd_i,
    input  logic        flush_i,
    output logic [31:0] ALU_result_o,
    output logic [31:0] WR_data_o,
    output logic [4:0]  RD_addr_o,
    output logic [1:0]  ctrl_WB_o,
    output logic [1:0]  ctrl_M_o,
    output logic        stall_o,
    output logic [1:0]  fsm_state_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_MUL = 6'b011000;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [4:0]  mul_rd;
    logic [1:0]  mul_wb;
    logic [1:0]  mul_m;

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    logic [4:0]  dest;
    logic [5:0]  funct;
    logic        is_mul;

    assign funct  = sign_extend_i[5:0];
    assign op_b   = ALUSrc_i ? sign_extend_i : fwd_b;
    assign dest   = RegDst_i ? instr1115_i : instr1620_i;
    assign is_mul = (ALUOp_i == 2'b10) && (funct == F_MUL);

    always_comb begin
        fwd_a = RS_data_i;
        case (ForwardA_i)
            2'b01:   fwd_a = MEM_WB_fwd_i;
            2'b10:   fwd_a = EX_MEM_fwd_i;
            default: fwd_a = RS_data_i;
        endcase
    end

    always_comb begin
        fwd_b = RT_data_i;
        case (ForwardB_i)
            2'b01:   fwd_b = MEM_WB_fwd_i;
            2'b10:   fwd_b = EX_MEM_fwd_i;
            default: fwd_b = RT_data_i;
        endcase
    end

    // mul is never produced here; it goes through the multi-cycle path instead
    always_comb begin
        alu_res = fwd_a + op_b;
        case (ALUOp_i)
            2'b01: alu_res = fwd_a - op_b;
            2'b10: begin
                case (funct)
                    F_ADD:   alu_res = fwd_a + op_b;
                    F_SUB:   alu_res = fwd_a - op_b;
                    F_AND:   alu_res = fwd_a & op_b;
                    F_OR:    alu_res = fwd_a | op_b;
                    default: alu_res = fwd_a + op_b;
                endcase
            end
            default: alu_res = fwd_a + op_b;
        endcase
    end

    // Held low during reset so the front end is never frozen by a stale decode
    assign stall_o     = rst_i && (((state == S_IDLE) && is_mul) || (state == S_BUSY));
    assign fsm_state_o = state;

    always_ff @(negedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= S_IDLE;
            cnt          <= 5'd0;
            acc          <= 32'd0;
            mcand        <= 32'd0;
            mplier       <= 32'd0;
            mul_rd       <= 5'd0;
            mul_wb       <= 2'd0;
            mul_m        <= 2'd0;
            ALU_result_o <= 32'd0;
            WR_data_o    <= 32'd0;
            RD_addr_o    <= 5'd0;
            ctrl_WB_o    <= 2'd0;
            ctrl_M_o     <= 2'd0;
        end else if (flush_i) begin
            state        <= S_IDLE;
            ALU_result_o <= 32'd0;
            WR_data_o    <= 32'd0;
            RD_addr_o    <= 5'd0;
            ctrl_WB_o    <= 2'd0;
            ctrl_M_o     <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_mul) begin
                        mcand        <= fwd_a;
                        mplier       <= op_b;
                        mul_rd       <= dest;
                        mul_wb       <= ctrl_WB_i;
                        mul_m        <= ctrl_M_i;
                        acc          <= 32'd0;
                        cnt          <= 5'd0;
                        state        <= S_BUSY;
                        ALU_result_o <= 32'd0;
                        WR_data_o    <= 32'd0;
                        RD_addr_o    <= 5'd0;
                        ctrl_WB_o    <= 2'd0;
                        ctrl_M_o     <= 2'd0;
                    end else begin
                        ALU_result_o <= alu_res;
                        WR_data_o    <= fwd_b;
                        RD_addr_o    <= dest;
                        ctrl_WB_o    <= ctrl_WB_i;
                        ctrl_M_o     <= ctrl_M_i;
                    end
                end
                S_BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand        <= mcand << 1;
                    mplier       <= mplier >> 1;
                    cnt          <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_DONE;
                    end
                    ALU_result_o <= 32'd0;
                    WR_data_o    <= 32'd0;
                    RD_addr_o    <= 5'd0;
                    ctrl_WB_o    <= 2'd0;
                    ctrl_M_o     <= 2'd0;
                end
                S_DONE: begin
                    ALU_result_o <= acc;
                    WR_data_o    <= 32'd0;
                    RD_addr_o    <= mul_rd;
                    ctrl_WB_o    <= mul_wb;
                    ctrl_M_o     <= mul_m;
                    state        <= S_IDLE;
                end
                default: begin
                    state        <= S_IDLE;
                    ALU_result_o <= 32'd0;
                    WR_data_o    <= 32'd0;
                    RD_addr_o    <= 5'd0;
                    ctrl_WB_o    <= 2'd0;
                    ctrl_M_o     <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed and randomized bench for ex_mem_stage, checked against an arithmetic reference
// model. State updates on the falling clock edge; outputs are sampled 1 time unit later.
module tb_ex_mem_stage;

    logic        clk_i = 1'b1;
    logic        rst_i;
    logic [31:0] RS_data_i, RT_data_i, sign_extend_i;
    logic        ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic        RegDst_i;
    logic [4:0]  instr1115_i, instr1620_i;
    logic [1:0]  ctrl_WB_i, ctrl_M_i, ForwardA_i, ForwardB_i;
    logic [31:0] EX_MEM_fwd_i, MEM_WB_fwd_i;
    logic        flush_i;
    logic [31:0] ALU_result_o, WR_data_o;
    logic [4:0]  RD_addr_o;
    logic [1:0]  ctrl_WB_o, ctrl_M_o;
    logic        stall_o;
    logic [1:0]  fsm_state_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    ex_mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RS_data_i(RS_data_i), .RT_data_i(RT_data_i), .sign_extend_i(sign_extend_i),
        .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i), .RegDst_i(RegDst_i),
        .instr1115_i(instr1115_i), .instr1620_i(instr1620_i),
        .ctrl_WB_i(ctrl_WB_i), .ctrl_M_i(ctrl_M_i),
        .ForwardA_i(ForwardA_i), .ForwardB_i(ForwardB_i),
        .EX_MEM_fwd_i(EX_MEM_fwd_i), .MEM_WB_fwd_i(MEM_WB_fwd_i),
        .flush_i(flush_i),
        .ALU_result_o(ALU_result_o), .WR_data_o(WR_data_o), .RD_addr_o(RD_addr_o),
        .ctrl_WB_o(ctrl_WB_o), .ctrl_M_o(ctrl_M_o), .stall_o(stall_o),
        .fsm_state_o(fsm_state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    function automatic logic [31:0] sel_fwd(logic [1:0] s, logic [31:0] reg_v);
        if (s == 2'b01) return MEM_WB_fwd_i;
        if (s == 2'b10) return EX_MEM_fwd_i;
        return reg_v;
    endfunction

    function automatic logic [31:0] ref_store();
        return sel_fwd(ForwardB_i, RT_data_i);
    endfunction

    function automatic logic [31:0] ref_result();
        logic [31:0] a, b;
        a = sel_fwd(ForwardA_i, RS_data_i);
        b = ALUSrc_i ? sign_extend_i : sel_fwd(ForwardB_i, RT_data_i);
        if (ALUOp_i == 2'b01) return a - b;
        if (ALUOp_i != 2'b10) return a + b;
        case (sign_extend_i[5:0])
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h18:   return a * b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [4:0] ref_dest();
        return RegDst_i ? instr1115_i : instr1620_i;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic set_nop();
        RS_data_i = 0; RT_data_i = 0; sign_extend_i = 0; ALUSrc_i = 0; ALUOp_i = 2'b00;
        RegDst_i = 0; instr1115_i = 0; instr1620_i = 0; ctrl_WB_i = 0; ctrl_M_i = 0;
        ForwardA_i = 0; ForwardB_i = 0; EX_MEM_fwd_i = 0; MEM_WB_fwd_i = 0; flush_i = 0;
    endtask

    task automatic set_random();
        RS_data_i = $urandom; RT_data_i = $urandom; sign_extend_i = $urandom;
        ALUSrc_i = 1'($urandom_range(0, 1)); ALUOp_i = 2'($urandom_range(0, 3));
        RegDst_i = 1'($urandom_range(0, 1));
        instr1115_i = 5'($urandom_range(0, 31)); instr1620_i = 5'($urandom_range(0, 31));
        ctrl_WB_i = 2'($urandom_range(0, 3)); ctrl_M_i = 2'($urandom_range(0, 3));
        ForwardA_i = 2'($urandom_range(0, 3)); ForwardB_i = 2'($urandom_range(0, 3));
        EX_MEM_fwd_i = $urandom; MEM_WB_fwd_i = $urandom; flush_i = 0;
    endtask

    task automatic set_random_single();
        logic [5:0] f;
        set_random();
        case ($urandom_range(0, 4))
            0: f = 6'h20;
            1: f = 6'h22;
            2: f = 6'h24;
            3: f = 6'h25;
            default: f = 6'($urandom_range(0, 63));
        endcase
        if (ALUOp_i == 2'b10 && f == 6'h18) f = 6'h20;
        sign_extend_i[5:0] = f;
    endtask

    // Applies a mul, checks stall/bubbles for 33 edges and the result at edge 34.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit randomize_ops,
                           input bit scramble);
        logic [4:0] exp_rd;
        logic [1:0] exp_wb, exp_m;
        if (randomize_ops) set_random();
        else begin
            set_nop();
            RS_data_i = a; RT_data_i = b;
            RegDst_i = 1; instr1115_i = 5'd17; ctrl_WB_i = 2'b10; ctrl_M_i = 2'b00;
        end
        ALUOp_i = 2'b10;
        sign_extend_i[5:0] = 6'h18;
        exp_q.push_back(ref_result());
        exp_rd = ref_dest(); exp_wb = ctrl_WB_i; exp_m = ctrl_M_i;
        #1;
        chk("mul_stall_idle", 32'(stall_o), 32'd1);
        for (int e = 1; e <= 33; e++) begin
            edge_step();
            chk("mul_bubble_wb", 32'(ctrl_WB_o), 32'd0);
            chk("mul_bubble_m", 32'(ctrl_M_o), 32'd0);
            if (scramble) begin
                set_random();
                #1;
            end
            if (e < 33) chk("mul_stall_busy", 32'(stall_o), 32'd1);
            else chk("mul_stall_done", 32'(stall_o), 32'd0);
        end
        edge_step();
        chk("mul_result", ALU_result_o, exp_q.pop_front());
        chk("mul_rd", 32'(RD_addr_o), 32'(exp_rd));
        chk("mul_wb", 32'(ctrl_WB_o), 32'(exp_wb));
        chk("mul_m", 32'(ctrl_M_o), 32'(exp_m));
        set_nop();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_res"}, ALU_result_o, 32'd0);
        chk({tag, "_wr"}, WR_data_o, 32'd0);
        chk({tag, "_rd"}, 32'(RD_addr_o), 32'd0);
        chk({tag, "_wb"}, 32'(ctrl_WB_o), 32'd0);
        chk({tag, "_m"}, 32'(ctrl_M_o), 32'd0);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [31:0] exp_st;
        logic [4:0]  exp_rd;
        logic [1:0]  exp_wb, exp_m;
        bit          fl;

        // reset with a mul decoded: stall must stay low
        set_nop();
        rst_i = 0;
        ALUOp_i = 2'b10; sign_extend_i = 32'h18;
        #3;
        chk_all_zero("reset");
        edge_step();
        rst_i = 1;
        set_nop();

        // add 5 + 7 -> rd 3
        RS_data_i = 5; RT_data_i = 7; ALUOp_i = 2'b10; sign_extend_i = 32'h20;
        RegDst_i = 1; instr1115_i = 3; instr1620_i = 9; ctrl_WB_i = 2'b10;
        #1 chk("add_stall", 32'(stall_o), 32'd0);
        edge_step();
        chk("add_res", ALU_result_o, 32'd12);
        chk("add_rd", 32'(RD_addr_o), 32'd3);
        chk("add_wb", 32'(ctrl_WB_o), 32'd2);

        // lw: 0x100 + 0xFFFFFFFC
        set_nop();
        RS_data_i = 32'h100; sign_extend_i = 32'hFFFF_FFFC; ALUSrc_i = 1;
        instr1620_i = 8; ctrl_WB_i = 2'b11; ctrl_M_i = 2'b10;
        edge_step();
        chk("lw_res", ALU_result_o, 32'h0000_00FC);
        chk("lw_rd", 32'(RD_addr_o), 32'd8);
        chk("lw_m", 32'(ctrl_M_o), 32'd2);

        // sub with operand A forwarded from EX/MEM
        set_nop();
        ForwardA_i = 2'b10; EX_MEM_fwd_i = 9; RS_data_i = 32'h5555; RT_data_i = 1;
        ALUOp_i = 2'b01;
        edge_step();
        chk("fwd_sub_res", ALU_result_o, 32'd8);

        // sw with store data forwarded from MEM/WB
        set_nop();
        RS_data_i = 32'h200; sign_extend_i = 4; ALUSrc_i = 1; ctrl_M_i = 2'b01;
        ForwardB_i = 2'b01; MEM_WB_fwd_i = 32'hCAFE_F00D; RT_data_i = 32'h1234;
        edge_step();
        chk("sw_wr", WR_data_o, 32'hCAFE_F00D);
        chk("sw_res", ALU_result_o, 32'h204);
        chk("sw_m", 32'(ctrl_M_o), 32'd1);

        // random single-cycle ops with occasional flush
        for (int i = 0; i < 60; i++) begin
            set_random_single();
            fl = ($urandom_range(0, 7) == 0);
            flush_i = fl;
            exp_q.push_back(ref_result());
            exp_st = ref_store(); exp_rd = ref_dest(); exp_wb = ctrl_WB_i; exp_m = ctrl_M_i;
            #1 chk("rnd_stall", 32'(stall_o), 32'd0);
            edge_step();
            if (fl) begin
                void'(exp_q.pop_front());
                chk("rnd_flush_wb", 32'(ctrl_WB_o), 32'd0);
                chk("rnd_flush_m", 32'(ctrl_M_o), 32'd0);
            end else begin
                chk("rnd_res", ALU_result_o, exp_q.pop_front());
                chk("rnd_wr", WR_data_o, exp_st);
                chk("rnd_rd", 32'(RD_addr_o), 32'(exp_rd));
                chk("rnd_wb", 32'(ctrl_WB_o), 32'(exp_wb));
                chk("rnd_m", 32'(ctrl_M_o), 32'(exp_m));
            end
        end

        // multiplies: directed, then random with operand scrambling while busy
        run_mul(32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
        chk("mul_ffff_x3", ALU_result_o, 32'hFFFF_FFFD);
        run_mul(32'd7, 32'd6, 1'b0, 1'b1);
        chk("mul_7x6", ALU_result_o, 32'd42);
        for (int i = 0; i < 4; i++) run_mul(32'd0, 32'd0, 1'b1, 1'b1);

        // single op right after a mul completes
        RS_data_i = 40; RT_data_i = 2; ctrl_WB_i = 2'b01;
        edge_step();
        chk("post_mul_add", ALU_result_o, 32'd42);

        // flush at busy edge 10
        set_nop();
        RS_data_i = 5; RT_data_i = 9; ALUOp_i = 2'b10; sign_extend_i = 32'h18;
        ctrl_WB_i = 2'b10;
        for (int e = 1; e <= 9; e++) edge_step();
        chk("flush_pre_stall", 32'(stall_o), 32'd1);
        set_nop();
        flush_i = 1; RS_data_i = 11; RT_data_i = 22; ctrl_WB_i = 2'b11;
        edge_step();
        chk("flush_wb", 32'(ctrl_WB_o), 32'd0);
        chk("flush_m", 32'(ctrl_M_o), 32'd0);
        flush_i = 0;
        #1 chk("flush_stall", 32'(stall_o), 32'd0);
        edge_step();
        chk("flush_next_res", ALU_result_o, 32'd33);
        chk("flush_next_wb", 32'(ctrl_WB_o), 32'd3);
        set_nop();
        for (int e = 0; e < 30; e++) begin
            edge_step();
            chk("flush_no_result", ALU_result_o | 32'(ctrl_WB_o), 32'd0);
        end

        // asynchronous reset clears live outputs
        RS_data_i = 32'hABCD; RT_data_i = 1; ctrl_WB_i = 2'b11; ctrl_M_i = 2'b11;
        RegDst_i = 1; instr1115_i = 31; ForwardB_i = 2'b00;
        edge_step();
        chk("pre_rst_res", ALU_result_o, 32'hABCE);
        #2 rst_i = 0;
        #1 chk_all_zero("async_rst");
        edge_step();
        rst_i = 1;

        // reset at busy edge 20
        set_nop();
        RS_data_i = 123; RT_data_i = 77; ALUOp_i = 2'b10; sign_extend_i = 32'h18;
        ctrl_WB_i = 2'b10;
        for (int e = 1; e <= 20; e++) edge_step();
        chk("rst_mid_stall_pre", 32'(stall_o), 32'd1);
        #2 rst_i = 0;
        #1 chk_all_zero("rst_mid_mul");
        edge_step();
        rst_i = 1;
        set_nop();
        RS_data_i = 100; RT_data_i = 23; ctrl_WB_i = 2'b01;
        #1 chk("rst_after_stall", 32'(stall_o), 32'd0);
        edge_step();
        chk("rst_after_add", ALU_result_o, 32'd123);
        chk("rst_after_wb", 32'(ctrl_WB_o), 32'd1);
        set_nop();
        for (int e = 0; e < 20; e++) begin
            edge_step();
            chk("rst_no_stale_mul", ALU_result_o | 32'(ctrl_WB_o), 32'd0);
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
